watch_set_ctrl: RTL
===================

Name: watch_set_ctrl

Overview:
- Timekeeping controller for a 12-hour hour/minute watch.
- Advances time on a one-cycle minute tick.
- Sequences a button-driven set mode for the time and for an alarm register.
- Raises a one-cycle alarm pulse on match.
- Sits between the board button synchronizers and the display/time datapath.

Parameters:
- HOUR_MAX, 11, last hour value; hour wraps HOUR_MAX -> 0
- MIN_MAX, 59, last minute value; minute wraps MIN_MAX -> 0
- TIMEOUT_CYC, 16, idle cycles in any SET state before automatic return to RUN
- BLINK_W, 4, blink toggles every 2**BLINK_W cycles

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- tick_min  in  1  one-cycle enable; advance time by one minute
- btn_mode  in  1  synchronized level; rising edge = mode press
- btn_inc  in  1  synchronized level; rising edge = increment press
- btn_alarm  in  1  synchronized level; rising edge = alarm on/off toggle
- hour  out  4  current hour 0..HOUR_MAX
- minute  out  6  current minute 0..MIN_MAX
- al_hour  out  4  alarm hour
- al_minute  out  6  alarm minute
- alarm_on  out  1  alarm armed
- alarm_hit  out  1  one-cycle alarm pulse
- mode  out  3  state encoding: RUN=0, SET_HOUR=1, SET_MIN=2, SET_AHOUR=3, SET_AMIN=4
- blink  out  1  display blink for the field being edited

Behaviour:
- Reset: hour, minute, al_hour, al_minute = 0; alarm_on, alarm_hit, blink = 0; mode = RUN; button history regs, idle counter and blink counter = 0.
- Press detection: press = btn & ~btn_q, where btn_q is btn registered.
  - Acts in the same cycle press is high.
  - A held button gives exactly one press.
- RUN:
  - tick_min: minute+1.
  - At minute==MIN_MAX: minute->0 and hour+1.
  - At hour==HOUR_MAX and minute==MIN_MAX: both ->0.
  - Mode press -> SET_HOUR.
  - Alarm press toggles alarm_on.
  - Inc press ignored.
- SET_HOUR / SET_MIN / SET_AHOUR / SET_AMIN:
  - tick_min ignored; time is frozen and ticks are lost.
  - Inc press increments the selected field with wrap at its max; no carry between fields.
  - Mode press advances SET_HOUR -> SET_MIN -> SET_AHOUR -> SET_AMIN -> RUN.
  - Alarm press ignored.
- Simultaneous events:
  - Mode and inc pressed in the same cycle: mode wins, inc discarded.
  - In RUN, tick_min and mode press in the same cycle: tick applied, and state goes to SET_HOUR.
- Timeout:
  - Idle counter increments each cycle in SET states.
  - Cleared on any mode/inc press and whenever state is RUN.
  - When it reaches TIMEOUT_CYC-1 without a press, the next edge forces RUN; edited values are kept.
- alarm_hit:
  - Registered; high for exactly one cycle.
  - Asserts on the same edge where a RUN tick makes the next {hour,minute} equal {al_hour,al_minute} with alarm_on=1.
  - Never asserts from SET-mode edits or from toggling alarm_on.
- blink:
  - 0 in RUN.
  - In SET states, toggles every 2**BLINK_W cycles from a counter that is cleared (blink=0) on every state change.
- Reset mid-operation: async rstn returns everything to reset values immediately, including from any SET state.
- Widths: all compares are unsigned at field width; values above max are unreachable.

Decomposition:
- Shared package watch_pkg holds:
  - mode enum (RUN..SET_AMIN, 3 bits)
  - HOUR_W=4, MIN_W=6
- One natural sub-module: btn_edge.
  - Per-button rising-edge detector with async reset.
  - Instantiated three times.

Test Plan:
- Reset, then 60 tick_min pulses in RUN -> minute 59->0 at tick 60, hour=1; alarm_hit stays 0.
- Preload 11:59 via SET mode, return to RUN, one tick -> hour=0, minute=0.
- From RUN: mode, inc x3, mode, inc x5, mode, mode, mode -> RUN, hour=3, minute=5; alarm regs unchanged.
- Set alarm 0:02, alarm press (alarm_on=1), two ticks from 0:00 -> alarm_hit high exactly one cycle, coincident with minute=2; with alarm_on=0, no pulse.
- Enter SET_MIN, no presses for TIMEOUT_CYC cycles -> mode=RUN; ticks in SET are lost; btn_mode held 10 cycles counts as one press.
- Mode and inc in the same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged; assert rstn low mid-SET -> all outputs 0, mode=RUN asynchronously.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: shared mode encoding and field widths for the watch controller
package watch_pkg;
  localparam int HOUR_W = 4;
  localparam int MIN_W = 6;
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } mode_e;
endpackage

// File: rtl/watch_set_ctrl_btn_edge.sv
// btn_edge: rising-edge press detector for one synchronized button level
module btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic press
);
  logic btn_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) btn_q <= 1'b0;
    else btn_q <= btn;
  assign press = btn & ~btn_q;
endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: 12-hour watch timekeeping with button-driven time/alarm set mode
import watch_pkg::*;
module watch_set_ctrl #(
  parameter int HOUR_MAX = 11,
  parameter int MIN_MAX = 59,
  parameter int TIMEOUT_CYC = 16,
  parameter int BLINK_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_min,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_alarm,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [HOUR_W-1:0] al_hour,
  output logic [MIN_W-1:0]  al_minute,
  output logic              alarm_on,
  output logic              alarm_hit,
  output logic [2:0]        mode,
  output logic              blink
);
  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam logic [HOUR_W-1:0] HMAX = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0] MMAX = MIN_W'(MIN_MAX);
  localparam logic [IW-1:0] TLAST = IW'(TIMEOUT_CYC - 1);
  mode_e st, nxt;
  logic p_mode, p_inc, p_alarm;
  logic [IW-1:0] idle;
  logic [BLINK_W-1:0] bcnt;
  logic [HOUR_W-1:0] hi, ahi, nh;
  logic [MIN_W-1:0] mi, ami, nm;
  btn_edge u_mode (.clk(clk), .rstn(rstn), .btn(btn_mode), .press(p_mode));
  btn_edge u_inc (.clk(clk), .rstn(rstn), .btn(btn_inc), .press(p_inc));
  btn_edge u_alarm (.clk(clk), .rstn(rstn), .btn(btn_alarm), .press(p_alarm));
  assign hi = hour == HMAX ? '0 : hour + 1'b1;
  assign mi = minute == MMAX ? '0 : minute + 1'b1;
  assign ahi = al_hour == HMAX ? '0 : al_hour + 1'b1;
  assign ami = al_minute == MMAX ? '0 : al_minute + 1'b1;
  assign nm = mi;
  assign nh = minute == MMAX ? hi : hour;
  assign mode = st;
  always_comb begin
    nxt = st;
    if (st == RUN) nxt = p_mode ? SET_HOUR : RUN;
    else if (p_mode) nxt = st == SET_AMIN ? RUN : mode_e'(st + 3'd1);
    else if (!p_inc && idle == TLAST) nxt = RUN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= RUN;
      hour <= '0;
      minute <= '0;
      al_hour <= '0;
      al_minute <= '0;
      alarm_on <= 1'b0;
      alarm_hit <= 1'b0;
      blink <= 1'b0;
      idle <= '0;
      bcnt <= '0;
    end else begin
      st <= nxt;
      alarm_hit <= 1'b0;
      idle <= (st == RUN || p_mode || p_inc) ? '0 : idle + 1'b1;
      if (nxt != st) begin
        bcnt <= '0;
        blink <= 1'b0;
      end else if (st != RUN) begin
        bcnt <= bcnt + 1'b1;
        if (&bcnt) blink <= ~blink;
      end
      if (st == RUN) begin
        if (tick_min) begin
          hour <= nh;
          minute <= nm;
          alarm_hit <= alarm_on && {nh, nm} == {al_hour, al_minute};
        end
        if (p_alarm) alarm_on <= ~alarm_on;
      end else if (p_inc && !p_mode) begin
        hour <= st == SET_HOUR ? hi : hour;
        minute <= st == SET_MIN ? mi : minute;
        al_hour <= st == SET_AHOUR ? ahi : al_hour;
        al_minute <= st == SET_AMIN ? ami : al_minute;
      end
    end
  end
endmodule
